// File: rtl/cluster_clock_gate_ctrl_pkg.sv
// Shared types for the cluster clock-gate controller: FSM state encoding and
// an elaboration-time helper for sizing the shared idle/wake counter.
package cluster_clock_gate_ctrl_pkg;

    // ON is all-zero so the reset value of the state register is 2'b00.
    typedef enum logic [1:0] {
        ON    = 2'b00,
        DRAIN = 2'b01,
        OFF   = 2'b10,
        WAKE  = 2'b11
    } gate_state_e;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/cluster_clock_gate_ctrl.sv
// Idle-driven clock-enable controller feeding the en_i pin of the cluster ICG.
// Runs on the free-running clock; every output is a registered copy of the next state.
module cluster_clock_gate_ctrl
    import cluster_clock_gate_ctrl_pkg::*;
#(
    parameter int IdleCycles = 16,
    parameter int WakeCycles = 4
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic enable_i,
    input  logic busy_i,
    input  logic wake_i,
    input  logic off_ack_i,
    output logic off_req_o,
    output logic clk_en_o,
    output logic clk_ready_o
);

    localparam int CntWidth = $clog2(max_int(IdleCycles, WakeCycles) + 1);
    localparam logic [CntWidth-1:0] IdleLast = CntWidth'(IdleCycles - 1);
    localparam logic [CntWidth-1:0] WakeLast = CntWidth'((WakeCycles > 0) ? WakeCycles - 1 : 0);

    if (IdleCycles < 1) begin : g_bad_idle_cycles
        $error("cluster_clock_gate_ctrl: IdleCycles must be >= 1");
    end
    if (WakeCycles < 0) begin : g_bad_wake_cycles
        $error("cluster_clock_gate_ctrl: WakeCycles must be >= 0");
    end

    gate_state_e           r_state;
    gate_state_e           w_state_nxt;
    logic [CntWidth-1:0]   r_cnt;
    logic [CntWidth-1:0]   w_cnt_nxt;
    logic                  r_off_req;
    logic                  r_clk_en;
    logic                  r_clk_ready;
    logic                  w_wake_cond;

    assign w_wake_cond = wake_i | busy_i | ~enable_i;

    // NOTE: every signal written here gets a default first, so no path leaves it
    // unassigned and no latch is inferred.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        unique case (r_state)
            ON: begin
                if (w_wake_cond) begin
                    w_cnt_nxt = '0;
                end else if (r_cnt == IdleLast) begin
                    w_state_nxt = DRAIN;
                    w_cnt_nxt   = '0;
                end else begin
                    w_cnt_nxt = r_cnt + CntWidth'(1);
                end
            end
            DRAIN: begin
                // Wake has priority over a simultaneous acknowledge.
                if (w_wake_cond) begin
                    w_state_nxt = ON;
                    w_cnt_nxt   = '0;
                end else if (off_ack_i) begin
                    w_state_nxt = OFF;
                    w_cnt_nxt   = '0;
                end
            end
            OFF: begin
                if (w_wake_cond) begin
                    w_state_nxt = (WakeCycles == 0) ? ON : WAKE;
                    w_cnt_nxt   = '0;
                end
            end
            WAKE: begin
                if (r_cnt == WakeLast) begin
                    w_state_nxt = ON;
                    w_cnt_nxt   = '0;
                end else begin
                    w_cnt_nxt = r_cnt + CntWidth'(1);
                end
            end
            default: begin
                w_state_nxt = ON;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state     <= ON;
            r_cnt       <= '0;
            r_off_req   <= 1'b0;
            r_clk_en    <= 1'b1;
            r_clk_ready <= 1'b1;
        end else begin
            r_state     <= w_state_nxt;
            r_cnt       <= w_cnt_nxt;
            r_off_req   <= (w_state_nxt == DRAIN);
            r_clk_en    <= (w_state_nxt != OFF);
            r_clk_ready <= (w_state_nxt == ON) || (w_state_nxt == DRAIN);
        end
    end

    assign off_req_o   = r_off_req;
    assign clk_en_o    = r_clk_en;
    assign clk_ready_o = r_clk_ready;

endmodule

// File: tb/tb_cluster_clock_gate_ctrl.sv
// Scoreboard bench: two controllers (WakeCycles=2 and WakeCycles=0) share one
// stimulus stream; a behavioural model predicts their outputs cycle by cycle.
module tb_cluster_clock_gate_ctrl;

    localparam int IDLE   = 4;
    localparam int WAKE_A = 2;
    localparam int WAKE_B = 0;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst, enable, busy, wake, ack;
    logic a_req, a_en, a_rdy;
    logic b_req, b_en, b_rdy;

    cluster_clock_gate_ctrl #(.IdleCycles(IDLE), .WakeCycles(WAKE_A)) u_dut_a (
        .clk_i(clk), .rst_i(rst), .enable_i(enable), .busy_i(busy), .wake_i(wake),
        .off_ack_i(ack), .off_req_o(a_req), .clk_en_o(a_en), .clk_ready_o(a_rdy)
    );

    cluster_clock_gate_ctrl #(.IdleCycles(IDLE), .WakeCycles(WAKE_B)) u_dut_b (
        .clk_i(clk), .rst_i(rst), .enable_i(enable), .busy_i(busy), .wake_i(wake),
        .off_ack_i(ack), .off_req_o(b_req), .clk_en_o(b_en), .clk_ready_o(b_rdy)
    );

    // Abstract view: an idle streak, an outstanding request, a stopped clock,
    // and a countdown of cycles left before the woken clock is usable.
    typedef struct {
        int streak;
        bit req;
        bit stopped;
        int wake_left;
    } model_t;

    typedef struct packed {
        logic a_req, a_en, a_rdy;
        logic b_req, b_en, b_rdy;
    } exp_t;

    exp_t   exp_q[$];
    model_t ma, mb;
    int     n_checks = 0;
    int     n_fail   = 0;

    function automatic model_t step(input model_t m, input bit r, input bit en,
                                    input bit bsy, input bit wk, input bit ak,
                                    input int wake_cycles);
        model_t n;
        bit     woken;
        n     = m;
        woken = wk | bsy | !en;
        if (r) begin
            n.streak = 0; n.req = 0; n.stopped = 0; n.wake_left = 0;
        end else if (m.wake_left > 0) begin
            n.wake_left = m.wake_left - 1;
        end else if (m.stopped) begin
            if (woken) begin
                n.stopped   = 0;
                n.wake_left = wake_cycles;
            end
        end else if (m.req) begin
            if (woken) begin
                n.req = 0;
            end else if (ak) begin
                n.req     = 0;
                n.stopped = 1;
            end
        end else if (woken) begin
            n.streak = 0;
        end else begin
            n.streak = m.streak + 1;
            if (n.streak == IDLE) begin
                n.req    = 1;
                n.streak = 0;
            end
        end
        return n;
    endfunction

    task automatic check(input string name, input logic act, input logic exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %b expected %b", name, $time, act, exp);
        end
    endtask

    task automatic drive(input bit r, input bit e, input bit b, input bit w, input bit a);
        exp_t x;
        @(negedge clk);
        rst = r; enable = e; busy = b; wake = w; ack = a;
        ma = step(ma, r, e, b, w, a, WAKE_A);
        mb = step(mb, r, e, b, w, a, WAKE_B);
        x.a_req = ma.req;
        x.a_en  = !ma.stopped;
        x.a_rdy = !ma.stopped && (ma.wake_left == 0);
        x.b_req = mb.req;
        x.b_en  = !mb.stopped;
        x.b_rdy = !mb.stopped && (mb.wake_left == 0);
        exp_q.push_back(x);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(0, 1, 0, 0, 0);
    endtask

    // From ON with a fresh streak: reach DRAIN, then acknowledge into OFF.
    task automatic go_off();
        idle(IDLE + 1);
        drive(0, 1, 0, 0, 1);
    endtask

    // Monitor: compares each registered output one edge after its stimulus.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("a_off_req", a_req, e.a_req);
                check("a_clk_en",  a_en,  e.a_en);
                check("a_ready",   a_rdy, e.a_rdy);
                check("b_off_req", b_req, e.b_req);
                check("b_clk_en",  b_en,  e.b_en);
                check("b_ready",   b_rdy, e.b_rdy);
                check("a_ready_implies_en", a_rdy & ~a_en, 1'b0);
                check("a_req_while_off",    a_req & ~a_en, 1'b0);
                check("b_ready_implies_en", b_rdy & ~b_en, 1'b0);
                check("b_req_while_off",    b_req & ~b_en, 1'b0);
            end
        end
    end

    initial begin
        rst = 1; enable = 1; busy = 0; wake = 0; ack = 0;
        ma = '{0, 0, 0, 0};
        mb = '{0, 0, 0, 0};

        drive(1, 1, 0, 0, 0);
        drive(1, 1, 0, 0, 0);

        // Four idle cycles, request, acknowledge, clock stops.
        idle(IDLE + 1);
        drive(0, 1, 0, 0, 1);
        idle(3);
        // Single-cycle wake pulse from OFF, then settle.
        drive(0, 1, 0, 1, 0);
        drive(0, 1, 0, 0, 0);
        drive(0, 1, 1, 0, 0);
        drive(0, 1, 1, 0, 0);

        // Idle streak broken at its third cycle, then a full streak.
        idle(2);
        drive(0, 1, 1, 0, 0);
        idle(IDLE + 1);
        // Wake and acknowledge together while draining.
        drive(0, 1, 0, 1, 1);
        idle(2);

        // Software disable while stopped wakes the clock.
        drive(0, 1, 1, 0, 0);
        go_off();
        drive(0, 1, 0, 0, 0);
        drive(0, 0, 0, 0, 0);
        drive(0, 0, 0, 0, 0);
        drive(0, 1, 1, 0, 0);
        drive(0, 1, 1, 0, 0);

        // Reset while stopped, and reset during the wake settle.
        drive(0, 1, 1, 0, 0);
        go_off();
        drive(0, 1, 0, 0, 0);
        drive(1, 1, 0, 0, 0);
        drive(0, 1, 1, 0, 0);
        go_off();
        drive(0, 1, 0, 1, 0);
        drive(1, 1, 0, 0, 0);
        drive(0, 1, 1, 0, 0);

        // Random traffic; idle is frequent enough to reach every state.
        for (int i = 0; i < 10000; i++) begin
            drive($urandom_range(0, 199) == 0,
                  $urandom_range(0, 19) != 0,
                  $urandom_range(0, 7) == 0,
                  $urandom_range(0, 15) == 0,
                  $urandom_range(0, 2) == 0);
        end

        drive(0, 1, 1, 0, 0);
        repeat (3) @(posedge clk);
        #2;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/cluster_clock_gate_ctrl.md
Name: cluster_clock_gate_ctrl

Overview:
Idle-driven clock-enable controller that produces the en_i input of the cluster clock-gating cell.
- Counts consecutive idle cycles of the cluster and requests permission from downstream units to stop the clock.
- On acknowledge, drops the gate enable; on any wake condition, restores it.
- Holds a ready flag low until a programmable settle time has elapsed.
- Runs on the ungated (free-running) cluster clock, upstream of the ICG.

Parameters:
IdleCycles, 16, consecutive idle cycles required before requesting clock-off; must be >= 1 (elaboration assertion).
WakeCycles, 4, cycles clk_en_o is high before clk_ready_o asserts; 0 allowed.
CntWidth, $clog2(max(IdleCycles,WakeCycles)+1), derived, not user-overridable.

Ports:
clk_i  in  1  free-running cluster clock (ungated side of ICG).
rst_i  in  1  synchronous, active-high reset.
enable_i  in  1  software permission to gate; 0 forces clock on.
busy_i  in  1  cluster activity; 1 = not idle.
wake_i  in  1  external wake request (event/interrupt), level.
off_ack_i  in  1  downstream units quiesced, safe to stop clock.
off_req_o  out  1  request to quiesce before clock stop.
clk_en_o  out  1  to ICG en_i; 1 = clock running.
clk_ready_o  out  1  gated clock stable and usable.

Behaviour:
- One clock, clk_i. Reset is synchronous and active-high on rst_i; all state is sampled and cleared on the clk_i edge while rst_i = 1.
- All outputs are registered; no combinational input-to-output path.
- Reset values:
  - state = ON
  - clk_en_o = 1, clk_ready_o = 1, off_req_o = 0
  - counter = 0
- wake_cond = wake_i | busy_i | !enable_i.
- FSM states: ON, DRAIN, OFF, WAKE.
- ON:
  - If wake_cond, counter clears to 0.
  - Otherwise counter increments.
  - When counter == IdleCycles-1 and !wake_cond, next state = DRAIN. Exactly IdleCycles consecutive idle cycles are required; off_req_o is visible the cycle after the IdleCycles-th idle cycle.
  - Counter saturates; no wrap.
- DRAIN:
  - off_req_o = 1; clk_en_o = 1; clk_ready_o = 1.
  - If wake_cond: abort to ON, off_req_o = 0 next cycle, counter = 0. Wake wins even if off_ack_i = 1 in the same cycle.
  - Else if off_ack_i: next state = OFF.
  - Else: stay in DRAIN indefinitely (no timeout).
- OFF:
  - clk_en_o = 0, clk_ready_o = 0, off_req_o = 0, all from the first OFF cycle. The enable drops one cycle after the ack is sampled.
  - If wake_cond: next state = WAKE, clk_en_o = 1 on the next cycle.
  - off_ack_i is ignored in this state.
- WAKE:
  - clk_en_o = 1, clk_ready_o = 0; counter counts from 0.
  - After WakeCycles cycles in WAKE, next state = ON with clk_ready_o = 1 and counter = 0.
  - WakeCycles = 0: OFF goes directly to ON (clk_en_o and clk_ready_o both rise together).
  - wake_cond is ignored in this state; idle cycles in WAKE do not count toward IdleCycles.
- Reset mid-operation, from any state: return to ON next edge with clk_en_o = 1 immediately registered, clk_ready_o = 1, off_req_o = 0.
- Invariants for verification:
  - clk_en_o == 0 implies state == OFF.
  - clk_ready_o == 1 implies clk_en_o == 1.
  - off_req_o and !clk_en_o are never both asserted.

Decomposition:
- Package cluster_clock_gate_ctrl_pkg holds the state enum (gate_state_e: ON, DRAIN, OFF, WAKE), encoded 2 bits, ON = 2'b00 so reset is all-zero.
- The counter is shared between the idle and wake phases and lives inline.
- No sub-module; the ICG itself is instantiated by the parent, not here.

Test Plan (IdleCycles=4, WakeCycles=2 unless stated):
1. Reset, enable_i=1, busy_i=0 for 4 cycles -> off_req_o rises in cycle 5. off_ack_i=1 in cycle 6 -> clk_en_o=0 and clk_ready_o=0 in cycle 7.
2. Idle streak broken: busy_i pulses at idle cycle 3 -> no off_req_o. Then 4 further idle cycles -> off_req_o asserted.
3. In DRAIN, wake_i and off_ack_i both 1 in the same cycle -> next cycle state ON, off_req_o=0, clk_en_o stays 1.
4. In OFF, wake_i pulse for 1 cycle -> clk_en_o=1 next cycle, clk_ready_o=0 for 2 cycles, then clk_ready_o=1.
5. WakeCycles=0 build, wake from OFF -> clk_en_o and clk_ready_o rise in the same cycle. enable_i=0 while in OFF -> same wake sequence.
6. rst_i asserted in OFF and in WAKE -> next cycle clk_en_o=1, clk_ready_o=1, off_req_o=0. The invariants above hold as assertions throughout random busy/wake/ack stimulus (10k cycles).
